uart_rx: RTL
============

// Module: uart_rx
//
// PURPOSE
// Oversampled 8N1 UART receiver, downstream of the baud tick generator.
// Consumes the 1-cycle oversampling tick, synchronises the serial rx line,
// validates the start bit, samples each bit at mid-bit and checks the stop bit.
// Presents received bytes on a valid/ready interface to the bus-side UART logic.
//
// PARAMETERS
// OVERSAMPLING  16  ticks per bit period; even, >= 4; must match baud generator
// DATA_BITS     8   data bits per frame, LSB first; 5..8
//
// PORTS
// clk        in   1          system clock
// rst_n      in   1          asynchronous reset, active-low
// tick       in   1          oversampling strobe from baud generator, 1 clk wide
// rx         in   1          asynchronous serial input, idle high
// data       out  DATA_BITS  received byte; stable while valid=1
// valid      out  1          byte available; held until ready accepted
// ready      in   1          consumer accepts byte when valid&ready
// frame_err  out  1          1-clk pulse: stop bit sampled low
// overrun    out  1          1-clk pulse: byte completed while valid still high
//
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, sync flops=1, tick count=0, bit count=0,
//   shift reg=0, data=0, valid=0, frame_err=0, overrun=0. Reset mid-frame
//   discards partial frame; receiver restarts hunting for a start bit.
// - rx passes through 2 flops (reset value 1); FSM uses only the synced value rs.
// - Tick counter (width clog2(OVERSAMPLING)) advances only on clk with tick=1.
// - FSM states and transitions:
//   IDLE : rs=0 -> START, tick count cleared. Ignores tick otherwise.
//   START: on tick count reaching OVERSAMPLING/2-1 (mid start bit) with tick:
//          rs=0 -> DATA, counts cleared; rs=1 -> IDLE (glitch rejected, no flags).
//   DATA : every OVERSAMPLING ticks sample rs into shift reg MSB, shift right
//          (LSB-first). After DATA_BITS samples -> STOP, tick count cleared.
//   STOP : after OVERSAMPLING ticks sample rs.
//          rs=1 -> deliver byte (below), -> IDLE.
//          rs=0 -> frame_err pulse, byte discarded, -> BREAK.
//   BREAK: wait for rs=1 -> IDLE (no start detection on a held-low line).
// - Delivery (clk edge of stop sample): if valid=0 or (valid&ready) same cycle:
//   data<=shift reg, valid<=1, no overrun. If valid=1 and ready=0: keep old
//   data, drop new byte, overrun pulse 1 clk.
// - valid&ready with no delivery: valid<=0 next clk; data holds last value.
// - Latency: valid rises 1 clk after the tick sampling stop bit centre
//   (~DATA_BITS+1.5 bit periods after synced falling edge, +2 clk sync).
// - tick held high continuously is legal (counts every clk).
// - frame_err and overrun never assert in the same cycle.
//
// TESTING (OVERSAMPLING=16, DATA_BITS=8, tick every 4 clk unless noted)
// 1. Send 0xA5 (start,1,0,1,0,0,1,0,1,stop), ready=1 -> one valid pulse,
//    data=0xA5, frame_err=0, overrun=0.
// 2. rx low for 4 ticks then high -> START aborts to IDLE, valid never asserts;
//    following frame 0x3C received correctly.
// 3. Send 0x00 with stop bit=0, hold rx low 3 bit periods -> frame_err one clk,
//    valid=0, FSM in BREAK until rx high; next frame 0x81 received as 0x81.
// 4. ready=0, send 0x55 then 0xC3 back-to-back -> valid stays 1, data=0x55,
//    overrun pulses once at second stop sample; then ready=1 -> valid drops.
// 5. ready pulsed high on exact clk of second byte delivery -> data=0xC3,
//    valid stays 1, overrun=0.
// 6. Assert rst_n=0 mid-DATA of 0xFF -> all outputs 0 immediately; after
//    release, frame 0x5A received with data=0x5A, no spurious flags.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampled 8N1 UART receiver.
// Synchronises rx, validates the start bit at mid-bit, samples each data bit
// at mid-bit (LSB first) and checks the stop bit. Received bytes go out on a
// valid/ready handshake. frame_err and overrun are single-cycle pulses.
module uart_rx #(
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLING);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Tick count at the centre of the start bit, and at one full bit period.
    localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    logic                 rx_meta_reg;
    logic                 rs;

    state_t               state_reg,     state_next;
    logic [TW-1:0]        tick_cnt_reg,  tick_cnt_next;
    logic [BW-1:0]        bit_cnt_reg,   bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,     shift_next;
    logic [DATA_BITS-1:0] data_reg,      data_next;
    logic                 valid_reg,     valid_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 overrun_reg,   overrun_next;

    // Two-flop synchroniser on the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rs          <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rs          <= rx_meta_reg;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_cnt_reg  <= tick_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Next-state logic: frame sequencing, byte delivery and error pulses.
    always_comb begin
        state_next     = state_reg;
        tick_cnt_next  = tick_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;

        // Consumer handshake; a delivery below in the same cycle overrides.
        if (valid_reg && ready) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (!rs) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (tick_cnt_reg == MID_CNT) begin
                        tick_cnt_next = '0;
                        bit_cnt_next  = '0;
                        // Still low at mid start bit: genuine frame, else glitch.
                        state_next    = rs ? IDLE : DATA;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_cnt_reg == LAST_CNT) begin
                        tick_cnt_next = '0;
                        // LSB arrives first, so shift right inserting at MSB.
                        shift_next    = {rs, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_next = '0;
                            state_next   = STOP;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + BW'(1);
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (tick_cnt_reg == LAST_CNT) begin
                        tick_cnt_next = '0;
                        if (rs) begin
                            state_next = IDLE;
                            if (!valid_reg || ready) begin
                                data_next  = shift_reg;
                                valid_next = 1'b1;
                            end else begin
                                // Previous byte still pending: keep it, drop this one.
                                overrun_next = 1'b1;
                            end
                        end else begin
                            frame_err_next = 1'b1;
                            state_next     = BREAK;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end

            BREAK: begin
                // A held-low line must return high before a new start is hunted.
                if (rs) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule
